// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, cent values and dispenser states.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_25   = 2'b11
    } coin_t;

    localparam int CENTS_5  = 5;
    localparam int CENTS_10 = 10;
    localparam int CENTS_25 = 25;

    localparam int AMT_W_DEF    = 7;
    localparam int INV_W_DEF    = 4;
    localparam int INV_INIT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EJECT  = 2'd2,
        ST_DONE   = 2'd3
    } disp_state_t;

    function automatic int coin_cents(coin_t c);
        int v;
        v = 0;
        unique case (c)
            COIN_5:  v = CENTS_5;
            COIN_10: v = CENTS_10;
            COIN_25: v = CENTS_25;
            default: v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_ctrl_if.sv
// Request and hopper handshakes of the change dispenser.
interface change_dispenser_ctrl_if #(
    parameter int AMT_W = 7
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             eject_valid;
    vend_pkg::coin_t  eject_coin;
    logic             eject_ready;

    modport master (
        output req_valid,
        output req_amount,
        output eject_ready,
        input  req_ready,
        input  eject_valid,
        input  eject_coin
    );

    modport slave (
        input  req_valid,
        input  req_amount,
        input  eject_ready,
        output req_ready,
        output eject_valid,
        output eject_coin
    );
endinterface

// File: rtl/change_dispenser_ctrl_coin_select.sv
// Greedy coin picker: largest in-stock coin not exceeding the amount owed.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 7,
    parameter int INV_W = 4
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [INV_W-1:0] inv_5,
    input  logic [INV_W-1:0] inv_10,
    input  logic [INV_W-1:0] inv_25,
    output coin_t            coin,
    output logic             found
);

    logic fit_5;
    logic fit_10;
    logic fit_25;

    assign fit_5  = (remaining >= AMT_W'(CENTS_5))  && (inv_5  != '0);
    assign fit_10 = (remaining >= AMT_W'(CENTS_10)) && (inv_10 != '0);
    assign fit_25 = (remaining >= AMT_W'(CENTS_25)) && (inv_25 != '0);

    always_comb begin
        coin  = COIN_NONE;
        found = 1'b0;
        if (fit_25) begin
            coin  = COIN_25;
            found = 1'b1;
        end else if (fit_10) begin
            coin  = COIN_10;
            found = 1'b1;
        end else if (fit_5) begin
            coin  = COIN_5;
            found = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser: pays a requested amount greedily, one coin per
// hopper handshake, tracking per-denomination stock and shortfall.
module change_dispenser_ctrl
    import vend_pkg::*;
#(
    parameter int AMT_W    = AMT_W_DEF,
    parameter int INV_W    = INV_W_DEF,
    parameter int INV_INIT = INV_INIT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    change_dispenser_ctrl_if.slave  bus,
    input  logic                    refill,
    output logic                    done,
    output logic                    short,
    output logic [AMT_W-1:0]        remaining,
    output logic [INV_W-1:0]        inv_5,
    output logic [INV_W-1:0]        inv_10,
    output logic [INV_W-1:0]        inv_25
);

    disp_state_t      state;
    disp_state_t      state_nx;
    logic [AMT_W-1:0] rem_q;
    logic             short_q;
    coin_t            coin_q;
    logic [INV_W-1:0] inv5_q;
    logic [INV_W-1:0] inv10_q;
    logic [INV_W-1:0] inv25_q;

    coin_t sel_coin;
    logic  sel_found;
    logic  accept;
    logic  take;
    logic  reload;

    coin_select #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_sel (
        .remaining (rem_q),
        .inv_5     (inv5_q),
        .inv_10    (inv10_q),
        .inv_25    (inv25_q),
        .coin      (sel_coin),
        .found     (sel_found)
    );

    // Handshake outputs decode the state register so reset drops them at once
    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.eject_valid = (state == ST_EJECT);
    assign bus.eject_coin  = bus.eject_valid ? coin_q : COIN_NONE;
    assign done            = (state == ST_DONE);

    assign accept = bus.req_ready && bus.req_valid;
    assign take   = bus.eject_valid && bus.eject_ready;
    assign reload = bus.req_ready && refill;

    assign short     = short_q;
    assign remaining = rem_q;
    assign inv_5     = inv5_q;
    assign inv_10    = inv10_q;
    assign inv_25    = inv25_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nx = ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_nx = sel_found ? ST_EJECT : ST_DONE;
            end
            ST_EJECT: begin
                if (bus.eject_ready) begin
                    state_nx = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            short_q <= 1'b0;
            coin_q  <= COIN_NONE;
        end else begin
            if (accept) begin
                rem_q   <= bus.req_amount;
                short_q <= 1'b0;
            end else if (take) begin
                rem_q <= rem_q - AMT_W'(coin_cents(coin_q));
            end
            if (state == ST_SELECT) begin
                if (sel_found) begin
                    coin_q <= sel_coin;
                end else begin
                    short_q <= (rem_q != '0);
                end
            end
        end
    end

    // Refill loads rather than adds, so stock is capped at INV_INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv5_q  <= INV_W'(INV_INIT);
            inv10_q <= INV_W'(INV_INIT);
            inv25_q <= INV_W'(INV_INIT);
        end else if (reload) begin
            inv5_q  <= INV_W'(INV_INIT);
            inv10_q <= INV_W'(INV_INIT);
            inv25_q <= INV_W'(INV_INIT);
        end else if (take) begin
            unique case (coin_q)
                COIN_5:  inv5_q  <= inv5_q  - INV_W'(1);
                COIN_10: inv10_q <= inv10_q - INV_W'(1);
                COIN_25: inv25_q <= inv25_q - INV_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench for change_dispenser_ctrl: vector table, corner
// sequences and randomized requests against a greedy payout model.
module tb_change_dispenser_ctrl;

    logic       clk;
    logic       rst_n;
    logic       refill;
    logic       done;
    logic       short;
    logic [6:0] remaining;
    logic [3:0] inv_5;
    logic [3:0] inv_10;
    logic [3:0] inv_25;

    change_dispenser_ctrl_if #(.AMT_W(7)) bus ();

    change_dispenser_ctrl #(
        .AMT_W    (7),
        .INV_W    (4),
        .INV_INIT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .refill    (refill),
        .done      (done),
        .short     (short),
        .remaining (remaining),
        .inv_5     (inv_5),
        .inv_10    (inv_10),
        .inv_25    (inv_25)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] amt;
        bit         rf;
        int         ncoin;
        int         rem;
        bit         shrt;
        int         i5;
        int         i10;
        int         i25;
        int         lat;
    } vec_t;

    vec_t       vecs[6];
    int         n_chk;
    int         n_err;
    int         m_stk[3];
    logic [1:0] exp_q[$];
    logic [1:0] got[$];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Greedy payout over plain stock counts: 5c, 10c, 25c at index 0..2
    task automatic model(input int amt, output int rem, output bit sh);
        int  vals[3];
        bit  found;
        vals = '{5, 10, 25};
        exp_q.delete();
        rem = amt;
        do begin
            found = 1'b0;
            for (int i = 2; i >= 0; i--) begin
                if (!found && vals[i] <= rem && m_stk[i] > 0) begin
                    found = 1'b1;
                    exp_q.push_back(2'(i + 1));
                    rem -= vals[i];
                    m_stk[i]--;
                end
            end
        end while (found);
        sh = (rem != 0);
    endtask

    task automatic model_full();
        for (int i = 0; i < 3; i++) m_stk[i] = 15;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, bus.req_ready}, 1);
    endtask

    task automatic do_refill();
        wait_idle();
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        model_full();
    endtask

    task automatic do_request(input logic [6:0] amt, input int pct,
                              input int stall, input bit pulse,
                              output int lat_out);
        int         lat;
        int         stalls;
        bit         prev_stall;
        logic [1:0] prev_coin;
        int         erem;
        bit         esh;
        bit         rdy;
        bit         pl;
        model(int'(amt), erem, esh);
        got.delete();
        stalls     = stall;
        pl         = pulse;
        prev_stall = 1'b0;
        prev_coin  = 2'b00;
        lat_out    = -1;
        wait_idle();
        bus.req_valid  = 1'b1;
        bus.req_amount = amt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (lat < 600) begin
            refill = 1'b0;
            if (done) begin
                lat_out = lat;
                break;
            end
            if (bus.eject_valid) begin
                if (prev_stall)
                    check("coin_stable", bus.eject_coin, prev_coin);
                if (pl) begin
                    refill = 1'b1;
                    pl     = 1'b0;
                end
                if (stalls > 0) begin
                    rdy = 1'b0;
                    stalls--;
                end else begin
                    rdy = ($urandom_range(99) < pct);
                end
                if (rdy) got.push_back(bus.eject_coin);
                prev_stall = !rdy;
                prev_coin  = bus.eject_coin;
            end else begin
                check("coin_idle_zero", bus.eject_coin, 0);
                rdy        = 1'($urandom_range(1));
                prev_stall = 1'b0;
            end
            bus.eject_ready = rdy;
            @(negedge clk);
            lat++;
        end
        bus.eject_ready = 1'b0;
        refill          = 1'b0;
        check("done_seen", {31'd0, lat_out > 0}, 1);
        check("coin_count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check("coin_seq", got[i], exp_q[i]);
        check("rem_model", remaining, erem);
        check("short_model", short, esh);
        check("inv5_model", inv_5, m_stk[0]);
        check("inv10_model", inv_10, m_stk[1]);
        check("inv25_model", inv_25, m_stk[2]);
    endtask

    initial begin
        int lat;
        n_chk = 0;
        n_err = 0;
        model_full();

        vecs[0] = '{7'd30,  1'b1, 2, 0, 1'b0, 14, 15, 14, -1};
        vecs[1] = '{7'd45,  1'b1, 3, 0, 1'b0, 15, 13, 14, -1};
        vecs[2] = '{7'd0,   1'b0, 0, 0, 1'b0, 15, 13, 14,  2};
        vecs[3] = '{7'd7,   1'b0, 1, 2, 1'b1, 14, 13, 14, -1};
        vecs[4] = '{7'd127, 1'b1, 5, 2, 1'b1, 15, 15, 10, -1};
        vecs[5] = '{7'd3,   1'b0, 0, 3, 1'b1, 15, 15, 10, -1};

        rst_n           = 1'b0;
        refill          = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_amount  = '0;
        bus.eject_ready = 1'b0;
        #12;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_eject_valid", bus.eject_valid, 0);
        check("rst_eject_coin", bus.eject_coin, 0);
        check("rst_done", done, 0);
        check("rst_short", short, 0);
        check("rst_remaining", remaining, 0);
        check("rst_inv", {inv_5, inv_10, inv_25}, 12'hFFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rf) do_refill();
            do_request(vecs[i].amt, 100, 0, 1'b0, lat);
            check("vec_ncoin", got.size(), vecs[i].ncoin);
            check("vec_rem", remaining, vecs[i].rem);
            check("vec_short", short, vecs[i].shrt);
            check("vec_inv5", inv_5, vecs[i].i5);
            check("vec_inv10", inv_10, vecs[i].i10);
            check("vec_inv25", inv_25, vecs[i].i25);
            if (vecs[i].lat >= 0) check("vec_latency", lat, vecs[i].lat);
        end
        repeat (4) @(negedge clk);
        check("short_held", short, 1);
        check("rem_held", remaining, 3);

        // First coin stalled three cycles
        do_refill();
        do_request(7'd45, 100, 3, 1'b0, lat);
        check("stall_c0", got.size() > 0 ? got[0] : 2'b00, 2'b11);
        check("stall_c1", got.size() > 1 ? got[1] : 2'b00, 2'b10);
        check("stall_c2", got.size() > 2 ? got[2] : 2'b00, 2'b10);
        check("stall_rem", remaining, 0);

        // Drain 5c then owe 30: no backtracking
        do_refill();
        for (int i = 0; i < 15; i++) do_request(7'd5, 100, 0, 1'b0, lat);
        check("drain_inv5", inv_5, 0);
        do_request(7'd30, 100, 0, 1'b0, lat);
        check("nob_short", short, 1);
        check("nob_rem", remaining, 5);
        check("nob_inv25", inv_25, 14);

        // Refill during EJECT is dropped
        do_request(7'd25, 100, 2, 1'b1, lat);
        check("ej_refill_inv25", inv_25, 13);
        check("ej_refill_inv5", inv_5, 0);

        // Reset while a coin is being offered
        wait_idle();
        bus.req_valid  = 1'b1;
        bus.req_amount = 7'd30;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_ej_valid", bus.eject_valid, 1);
        check("mid_ej_coin", bus.eject_coin, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.eject_valid, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        check("mid_rst_inv", {inv_5, inv_10, inv_25}, 12'hFFF);
        @(negedge clk);
        rst_n = 1'b1;
        model_full();

        // Refill in IDLE after draining
        do_request(7'd127, 100, 0, 1'b0, lat);
        check("pre_refill_inv25", inv_25, 10);
        do_refill();
        check("refill_inv", {inv_5, inv_10, inv_25}, 12'hFFF);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) do_refill();
            do_request(7'($urandom_range(127)), $urandom_range(30, 100),
                       0, 1'b0, lat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
